// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection phase scheduler: lamp codes, phase encoding,
// preemption direction and the round-robin service picker.
package traffic_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef enum logic [2:0] {
    PH_ALL_RED  = 3'd0,
    PH_NS_G     = 3'd1,
    PH_NS_Y     = 3'd2,
    PH_EW_G     = 3'd3,
    PH_EW_Y     = 3'd4,
    PH_PED_WALK = 3'd5,
    PH_EMG_HOLD = 3'd6
  } phase_e;

  localparam logic DIR_NS = 1'b0;
  localparam logic DIR_EW = 1'b1;

  typedef enum logic [1:0] {
    SVC_NS  = 2'd0,
    SVC_EW  = 2'd1,
    SVC_PED = 2'd2
  } svc_e;

  typedef struct packed {
    logic hit;
    svc_e svc;
  } rr_grant_t;

  function automatic svc_e svc_next(input svc_e cur);
    svc_e nxt;
    case (cur)
      SVC_NS:  nxt = SVC_EW;
      SVC_EW:  nxt = SVC_PED;
      default: nxt = SVC_NS;
    endcase
    return nxt;
  endfunction

  // req bit order follows svc_e: {ped, ew, ns}; search starts just after last.
  function automatic rr_grant_t rr_pick(input svc_e last, input logic [2:0] req);
    rr_grant_t g;
    svc_e      cand;
    g.hit = 1'b0;
    g.svc = SVC_NS;
    cand  = last;
    for (int i = 0; i < 3; i++) begin
      cand = svc_next(cand);
      if (!g.hit && req[cand]) begin
        g.hit = 1'b1;
        g.svc = cand;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Phase timer: counts cycles since phase entry, clears synchronously, holds at all-ones.
module tl_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-road intersection phase scheduler with pedestrian walk phase, yellow/all-red clearance
// and emergency preemption. All outputs are registered decodes of the phase being entered.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW    = 3,
  parameter int ALL_RED   = 2,
  parameter int WALK      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       emergency,
  input  logic       emg_dir,
  input  logic       ns_req,
  input  logic       ew_req,
  input  logic       ped_req,
  output logic [2:0] NS_light,
  output logic [2:0] EW_light,
  output logic       walk,
  output logic [2:0] phase,
  output logic       emg_active
);

  localparam logic [CNT_W-1:0] T_MIN  = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] T_MAX  = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] T_YEL  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALL_RED - 1);
  localparam logic [CNT_W-1:0] T_WALK = CNT_W'(WALK - 1);

  phase_e           r_phase;
  logic             r_ped_pend;
  logic             r_emg_pend;
  logic             r_emg_dir;
  svc_e             r_last;
  logic [2:0]       r_ns_light;
  logic [2:0]       r_ew_light;
  logic             r_walk;
  logic             r_emg_active;

  phase_e           w_phase_nxt;
  logic             w_clr;
  logic [CNT_W-1:0] w_cnt;
  logic             w_ns_conf;
  logic             w_ew_conf;
  rr_grant_t        w_grant;
  logic [2:0]       w_ns_lamp;
  logic [2:0]       w_ew_lamp;

  tl_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_clr   (w_clr),
    .o_cnt   (w_cnt)
  );

  always_comb begin
    w_ns_conf   = ew_req | r_ped_pend;
    w_ew_conf   = ns_req | r_ped_pend;
    w_grant     = rr_pick(r_last, {r_ped_pend, ew_req, ns_req});
    w_phase_nxt = r_phase;
    case (r_phase)
      PH_ALL_RED: begin
        if (w_cnt >= T_AR) begin
          if (r_emg_pend) begin
            w_phase_nxt = PH_EMG_HOLD;
          end else if (!w_grant.hit) begin
            w_phase_nxt = PH_NS_G;
          end else begin
            case (w_grant.svc)
              SVC_EW:  w_phase_nxt = PH_EW_G;
              SVC_PED: w_phase_nxt = PH_PED_WALK;
              default: w_phase_nxt = PH_NS_G;
            endcase
          end
        end
      end
      PH_NS_G: begin
        // Preemption for our own direction keeps the green lit straight into the hold.
        if (r_emg_pend) begin
          w_phase_nxt = (r_emg_dir == DIR_NS) ? PH_EMG_HOLD : PH_NS_Y;
        end else if (w_ns_conf && ((w_cnt >= T_MIN && !ns_req) || w_cnt >= T_MAX)) begin
          w_phase_nxt = PH_NS_Y;
        end
      end
      PH_EW_G: begin
        if (r_emg_pend) begin
          w_phase_nxt = (r_emg_dir == DIR_EW) ? PH_EMG_HOLD : PH_EW_Y;
        end else if (w_ew_conf && ((w_cnt >= T_MIN && !ew_req) || w_cnt >= T_MAX)) begin
          w_phase_nxt = PH_EW_Y;
        end
      end
      PH_NS_Y: begin
        if (w_cnt >= T_YEL) w_phase_nxt = PH_ALL_RED;
      end
      PH_EW_Y: begin
        if (w_cnt >= T_YEL) w_phase_nxt = PH_ALL_RED;
      end
      PH_PED_WALK: begin
        if (r_emg_pend || w_cnt >= T_WALK) w_phase_nxt = PH_ALL_RED;
      end
      PH_EMG_HOLD: begin
        if (!emergency) w_phase_nxt = (r_emg_dir == DIR_NS) ? PH_NS_Y : PH_EW_Y;
      end
      default: w_phase_nxt = PH_ALL_RED;
    endcase
  end

  assign w_clr = (w_phase_nxt != r_phase);

  always_comb begin
    w_ns_lamp = LAMP_RED;
    w_ew_lamp = LAMP_RED;
    case (w_phase_nxt)
      PH_NS_G:     w_ns_lamp = LAMP_GRN;
      PH_NS_Y:     w_ns_lamp = LAMP_YEL;
      PH_EW_G:     w_ew_lamp = LAMP_GRN;
      PH_EW_Y:     w_ew_lamp = LAMP_YEL;
      PH_EMG_HOLD: begin
        if (r_emg_dir == DIR_NS) w_ns_lamp = LAMP_GRN;
        else                     w_ew_lamp = LAMP_GRN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase      <= PH_ALL_RED;
      r_ped_pend   <= 1'b0;
      r_emg_pend   <= 1'b0;
      r_emg_dir    <= DIR_NS;
      r_last       <= SVC_PED;
      r_ns_light   <= LAMP_RED;
      r_ew_light   <= LAMP_RED;
      r_walk       <= 1'b0;
      r_emg_active <= 1'b0;
    end else begin
      r_phase      <= w_phase_nxt;
      r_ns_light   <= w_ns_lamp;
      r_ew_light   <= w_ew_lamp;
      r_walk       <= (w_phase_nxt == PH_PED_WALK);
      r_emg_active <= (w_phase_nxt == PH_EMG_HOLD);

      // Entering the walk wins over a button press on the same edge.
      if (w_clr && w_phase_nxt == PH_PED_WALK) begin
        r_ped_pend <= 1'b0;
      end else if (ped_req && r_phase != PH_PED_WALK) begin
        r_ped_pend <= 1'b1;
      end

      if (r_phase == PH_EMG_HOLD && !emergency) begin
        r_emg_pend <= 1'b0;
      end else if (emergency && r_phase != PH_EMG_HOLD) begin
        r_emg_pend <= 1'b1;
        if (!r_emg_pend) r_emg_dir <= emg_dir;
      end

      if (w_clr) begin
        case (w_phase_nxt)
          PH_NS_G:     r_last <= SVC_NS;
          PH_EW_G:     r_last <= SVC_EW;
          PH_PED_WALK: r_last <= SVC_PED;
          default:     ;
        endcase
      end
    end
  end

  assign NS_light   = r_ns_light;
  assign EW_light   = r_ew_light;
  assign walk       = r_walk;
  assign phase      = r_phase;
  assign emg_active = r_emg_active;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench for traffic_phase_scheduler: walks the phase sequences cycle by cycle and
// checks phase, lamps, walk and emg_active against hand-derived expectations.
module tb_traffic_phase_scheduler;
  import traffic_pkg::*;

  logic       clk;
  logic       rst;
  logic       emergency;
  logic       emg_dir;
  logic       ns_req;
  logic       ew_req;
  logic       ped_req;
  logic [2:0] NS_light;
  logic [2:0] EW_light;
  logic       walk;
  logic [2:0] phase;
  logic       emg_active;

  int n_cmp = 0;
  int n_err = 0;
  logic edir = 1'b0;

  traffic_phase_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .emergency  (emergency),
    .emg_dir    (emg_dir),
    .ns_req     (ns_req),
    .ew_req     (ew_req),
    .ped_req    (ped_req),
    .NS_light   (NS_light),
    .EW_light   (EW_light),
    .walk       (walk),
    .phase      (phase),
    .emg_active (emg_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] exp_ns(input phase_e ph, input logic ed);
    case (ph)
      PH_NS_G:     return 3'b001;
      PH_NS_Y:     return 3'b010;
      PH_EMG_HOLD: return (ed == 1'b0) ? 3'b001 : 3'b100;
      default:     return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] exp_ew(input phase_e ph, input logic ed);
    case (ph)
      PH_EW_G:     return 3'b001;
      PH_EW_Y:     return 3'b010;
      PH_EMG_HOLD: return (ed == 1'b1) ? 3'b001 : 3'b100;
      default:     return 3'b100;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input string what, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s.%s: observed %0d expected %0d", tag, what, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input phase_e ph);
    chk(tag, "phase", {5'b0, phase}, {5'b0, ph});
    chk(tag, "NS_light", {5'b0, NS_light}, {5'b0, exp_ns(ph, edir)});
    chk(tag, "EW_light", {5'b0, EW_light}, {5'b0, exp_ew(ph, edir)});
    chk(tag, "walk", {7'b0, walk}, {7'b0, ph == PH_PED_WALK});
    chk(tag, "emg_active", {7'b0, emg_active}, {7'b0, ph == PH_EMG_HOLD});
  endtask

  // Checks the current cycle and the following n-1 cycles are all in ph, ending one tick later.
  task automatic run_phase(input string tag, input phase_e ph, input int n);
    for (int i = 0; i < n; i++) begin
      check_out(tag, ph);
      tick();
    end
  endtask

  initial begin
    rst = 1'b0; emergency = 1'b0; emg_dir = 1'b0;
    ns_req = 1'b0; ew_req = 1'b0; ped_req = 1'b0;

    // 1: reset, release, rest in NS green
    tick(); tick();
    check_out("t1_in_reset", PH_ALL_RED);
    rst = 1'b1;
    run_phase("t1_ar", PH_ALL_RED, 2);
    check_out("t1_ns_entry", PH_NS_G);

    // 2: EW request at timer 0, NS idle -> minimum green
    ew_req = 1'b1;
    run_phase("t2_nsg", PH_NS_G, 4);
    run_phase("t2_nsy", PH_NS_Y, 3);
    run_phase("t2_ar", PH_ALL_RED, 2);

    // 3: both requests held -> maximum green
    ns_req = 1'b1;
    run_phase("t3_ewg", PH_EW_G, 12);
    run_phase("t3_ewy", PH_EW_Y, 3);
    run_phase("t3_ar", PH_ALL_RED, 2);

    // 4: pedestrian pulse while both roads demand service
    ped_req = 1'b1;
    check_out("t4_nsg_pulse", PH_NS_G);
    tick();
    ped_req = 1'b0;
    run_phase("t4_nsg", PH_NS_G, 11);
    run_phase("t4_nsy", PH_NS_Y, 3);
    run_phase("t4_ar1", PH_ALL_RED, 2);
    run_phase("t4_ewg", PH_EW_G, 12);
    run_phase("t4_ewy", PH_EW_Y, 3);
    check_out("t4_ar2a", PH_ALL_RED);
    tick();
    check_out("t4_ar2b", PH_ALL_RED);
    ped_req = 1'b1;  // press coincides with walk entry and must be dropped
    tick();
    ped_req = 1'b0;
    run_phase("t4_walk", PH_PED_WALK, 6);
    run_phase("t4_ar3", PH_ALL_RED, 2);
    ns_req = 1'b0; ew_req = 1'b0;
    run_phase("t4_ns_rest", PH_NS_G, 10);
    check_out("t4_ns_rest_end", PH_NS_G);

    // timer saturation: unsaturated count would wrap to 1 here and block the exit
    repeat (247) tick();
    check_out("sat_rest", PH_NS_G);
    ew_req = 1'b1;
    tick();
    run_phase("sat_nsy", PH_NS_Y, 3);
    run_phase("sat_ar", PH_ALL_RED, 2);

    // 5: emergency for NS while EW is green
    ew_req = 1'b0;
    check_out("t5_ewg0", PH_EW_G);
    tick(); tick();
    check_out("t5_ewg2", PH_EW_G);
    emergency = 1'b1; emg_dir = 1'b0;
    tick();
    check_out("t5_latch", PH_EW_G);
    tick();
    run_phase("t5_ewy", PH_EW_Y, 3);
    run_phase("t5_ar", PH_ALL_RED, 2);
    edir = 1'b0;
    emg_dir = 1'b1;  // must not retarget an active preemption
    run_phase("t5_hold", PH_EMG_HOLD, 13);
    check_out("t5_hold_last", PH_EMG_HOLD);
    emergency = 1'b0; ew_req = 1'b1;
    tick();
    run_phase("t5_nsy", PH_NS_Y, 3);
    run_phase("t5_ar2", PH_ALL_RED, 2);

    // 6: emergency during walk, then reset mid-yellow
    ew_req = 1'b0; ped_req = 1'b1;
    check_out("t6_ewg0", PH_EW_G);
    tick();
    ped_req = 1'b0;
    run_phase("t6_ewg", PH_EW_G, 3);
    run_phase("t6_ewy", PH_EW_Y, 3);
    run_phase("t6_ar", PH_ALL_RED, 2);
    check_out("t6_walk0", PH_PED_WALK);
    tick();
    check_out("t6_walk1", PH_PED_WALK);
    emergency = 1'b1; emg_dir = 1'b1;
    tick();
    check_out("t6_emg_latch", PH_PED_WALK);
    tick();
    edir = 1'b1;
    run_phase("t6_walk_drop", PH_ALL_RED, 2);
    check_out("t6_hold_ew", PH_EMG_HOLD);
    emergency = 1'b0;
    tick();
    check_out("t6_ewy", PH_EW_Y);
    #3;
    rst = 1'b0;
    #1;
    check_out("t6_async_rst", PH_ALL_RED);
    tick();
    check_out("t6_rst_held", PH_ALL_RED);
    rst = 1'b1;
    run_phase("t6_ar_post", PH_ALL_RED, 2);
    run_phase("t6_ns_rest", PH_NS_G, 6);
    check_out("t6_ns_rest_end", PH_NS_G);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
